// File: rtl/fir_mac_sequencer_if.sv
// MAC bus between the FIR sequencer (master) and the multiply-accumulate unit (slave).
`timescale 1ns/1ps
interface fir_mac_sequencer_if #(
  parameter int unsigned WIDTH = 24
);
  logic                   mac_reset;
  logic                   mac_wren;
  logic                   mac_rden;
  logic [WIDTH-1:0]       mac_m1;
  logic [WIDTH-1:0]       mac_m2;
  logic [2*WIDTH-1:0]     mac_accum;

  modport master (
    output mac_reset, mac_wren, mac_rden, mac_m1, mac_m2,
    input  mac_accum
  );

  modport slave (
    input  mac_reset, mac_wren, mac_rden, mac_m1, mac_m2,
    output mac_accum
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// FIR MAC sequencer: buffers decimator samples, and once per DECIM inputs
// clears the MAC, streams TAPS sample/coefficient pairs, flushes, reads and
// captures the filtered result.
`timescale 1ns/1ps
module fir_mac_sequencer #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned TAPS  = 64,
  parameter int unsigned TAP_W = 6,
  parameter int unsigned DECIM = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_strobe,
  input  logic [WIDTH-1:0]     in_data,
  output logic [TAP_W-1:0]     coef_addr,
  input  logic [WIDTH-1:0]     coef_data,
  fir_mac_sequencer_if.master  mac,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 out_strobe,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned AW    = TAP_W + 1;
  localparam int unsigned DEPTH = 2 * TAPS;
  localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, PRIME, RUN, FLUSH, READ, CAPTURE
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      base_q;
  logic [PH_W-1:0]    phase_q;
  logic [TAP_W-1:0]   coef_addr_q;
  logic [TAP_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rd_data_q;
  logic [2*WIDTH-1:0] out_data_q;
  logic               out_strobe_q;
  logic               overrun_q;
  logic [WIDTH-1:0]   ram [DEPTH];
  logic [AW-1:0]      rd_addr;
  logic               trigger;

  assign trigger    = in_strobe && (phase_q == PH_LAST);
  assign busy       = (state_q != IDLE);
  assign coef_addr  = coef_addr_q;
  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;
  assign overrun    = overrun_q;

  // Sample address tracks the coefficient address, so the sample for tap k
  // is read in the same cycle its coefficient is fetched.
  assign rd_addr = base_q - {1'b0, coef_addr_q};

  // Sample RAM: write on every strobe, registered read-before-write.
  always_ff @(posedge clk) begin
    if (in_strobe) begin
      ram[wr_ptr_q] <= in_data;
    end
    rd_data_q <= ram[rd_addr];
  end

  // Next-state and MAC control decode; operands forced to zero unless accumulating.
  always_comb begin
    state_d       = state_q;
    mac.mac_reset = 1'b0;
    mac.mac_wren  = 1'b0;
    mac.mac_rden  = 1'b0;
    mac.mac_m1    = '0;
    mac.mac_m2    = '0;
    unique case (state_q)
      IDLE:    if (trigger) state_d = CLEAR;
      CLEAR: begin
        mac.mac_reset = 1'b1;
        state_d       = PRIME;
      end
      PRIME:   state_d = RUN;
      RUN: begin
        mac.mac_wren = 1'b1;
        mac.mac_m1   = rd_data_q;
        mac.mac_m2   = coef_data;
        if (cnt_q == TAP_LAST) state_d = FLUSH;
      end
      FLUSH: begin
        mac.mac_wren = 1'b1;
        state_d      = READ;
      end
      READ: begin
        mac.mac_rden = 1'b1;
        state_d      = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers: pointers, phase, tap counters, result capture and pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      base_q       <= '0;
      phase_q      <= '0;
      coef_addr_q  <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      overrun_q    <= trigger && busy;
      out_strobe_q <= (state_q == CAPTURE);
      if (in_strobe) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        phase_q  <= trigger ? '0 : phase_q + 1'b1;
      end
      if (trigger && !busy) begin
        base_q <= wr_ptr_q;
      end
      if (state_q == CAPTURE) begin
        out_data_q <= mac.mac_accum;
      end
      // coef_addr runs one tap ahead of the operands and parks on the last tap.
      case (state_q)
        CLEAR: coef_addr_q <= '0;
        PRIME: begin
          coef_addr_q <= TAP_W'(1);
          cnt_q       <= '0;
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (coef_addr_q != TAP_LAST) coef_addr_q <= coef_addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a behavioural MAC and coefficient ROM.
`timescale 1ns/1ps
module tb_fir_mac_sequencer;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned TAPS  = 4;
  localparam int unsigned TAP_W = 2;
  localparam int unsigned DECIM = 2;

  logic                 clk       = 1'b0;
  logic                 reset     = 1'b0;
  logic                 in_strobe = 1'b0;
  logic [WIDTH-1:0]     in_data   = '0;
  logic [TAP_W-1:0]     coef_addr;
  logic [WIDTH-1:0]     coef_data;
  logic [2*WIDTH-1:0]   out_data;
  logic                 out_strobe;
  logic                 busy;
  logic                 overrun;

  fir_mac_sequencer_if #(.WIDTH(WIDTH)) mac ();

  fir_mac_sequencer #(.WIDTH(WIDTH), .TAPS(TAPS), .TAP_W(TAP_W), .DECIM(DECIM)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_strobe (in_strobe),
    .in_data   (in_data),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .mac       (mac),
    .out_data  (out_data),
    .out_strobe(out_strobe),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Coefficient ROM, one-cycle registered read.
  logic [WIDTH-1:0] coef_rom [TAPS];
  always @(posedge clk) coef_data <= coef_rom[coef_addr];

  // MAC: sync clear, pipelined product, accum_out = sum >> 1 latched on rden.
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH:0]   acc;
  always @(posedge clk) begin
    if (mac.mac_reset) begin
      prod <= '0;
      acc  <= '0;
    end else if (mac.mac_wren) begin
      prod <= $signed(mac.mac_m1) * $signed(mac.mac_m2);
      acc  <= acc + {prod[2*WIDTH-1], prod};
    end else if (mac.mac_rden) begin
      mac.mac_accum <= acc[2*WIDTH:1];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge.
  int n_rst, n_wren, n_rden, n_busy, n_ovr, n_viol;
  int t_rst, t_wren, t_wren_last, t_rden, t_busy, t_out, t_ovr;
  logic [WIDTH-1:0]   last_m1, last_m2;
  logic [2*WIDTH-1:0] outs [$];

  task automatic clr_mon();
    n_rst = 0; n_wren = 0; n_rden = 0; n_busy = 0; n_ovr = 0;
    t_rst = -1; t_wren = -1; t_wren_last = -1; t_rden = -1;
    t_busy = -1; t_out = -1; t_ovr = -1;
    outs.delete();
  endtask

  initial begin
    n_viol = 0;
    clr_mon();
  end

  always @(negedge clk) begin
    if (reset) begin
      if (mac.mac_reset) begin n_rst++; if (t_rst < 0) t_rst = cyc; end
      if (mac.mac_wren) begin
        n_wren++;
        if (t_wren < 0) t_wren = cyc;
        t_wren_last = cyc;
        last_m1 = mac.mac_m1;
        last_m2 = mac.mac_m2;
      end
      if (mac.mac_rden) begin n_rden++; if (t_rden < 0) t_rden = cyc; end
      if (busy) begin n_busy++; if (t_busy < 0) t_busy = cyc; end
      if (overrun) begin n_ovr++; if (t_ovr < 0) t_ovr = cyc; end
      if (out_strobe) begin outs.push_back(out_data); if (t_out < 0) t_out = cyc; end
      if (int'(mac.mac_reset) + int'(mac.mac_wren) + int'(mac.mac_rden) > 1) n_viol++;
      if (!mac.mac_wren && (mac.mac_m1 != '0 || mac.mac_m2 != '0)) n_viol++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [WIDTH-1:0] v, input int gap);
    in_strobe = 1'b1;
    in_data   = v;
    @(posedge clk); #1;
    in_strobe = 1'b0;
    in_data   = '0;
    idle(gap);
  endtask

  task automatic set_coefs(input logic [WIDTH-1:0] c0, c1, c2, c3);
    coef_rom[0] = c0; coef_rom[1] = c1; coef_rom[2] = c2; coef_rom[3] = c3;
  endtask

  // Eight zero samples, then a unit impulse and seven zeros, paced so triggers
  // land exactly TAPS+6 cycles apart.
  task automatic impulse_run(input string tag);
    for (int i = 0; i < 8; i++) send('0, 4);
    idle(12);
    clr_mon();
    send(16'd1, 4);
    for (int i = 0; i < 7; i++) send('0, 4);
    idle(12);
    chk({tag, " count"}, outs.size(), 4);
    chk({tag, " y0"}, outs[0], 32'd2);
    chk({tag, " y1"}, outs[1], 32'd4);
    chk({tag, " y2"}, outs[2], 32'd0);
    chk({tag, " y3"}, outs[3], 32'd0);
    chk({tag, " overrun"}, n_ovr, 0);
  endtask

  int t_trig;

  initial begin
    set_coefs(16'd2, 16'd4, 16'd6, 16'd8);

    // Reset state
    idle(2);
    chk("rst busy", busy, 0);
    chk("rst out_strobe", out_strobe, 0);
    chk("rst overrun", overrun, 0);
    chk("rst mac_reset", mac.mac_reset, 0);
    chk("rst mac_wren", mac.mac_wren, 0);
    chk("rst mac_rden", mac.mac_rden, 0);
    chk("rst coef_addr", coef_addr, 0);
    chk("rst out_data", out_data, 0);
    reset = 1'b1;
    idle(1);

    // Impulse response with back-to-back runs
    impulse_run("impulse");
    chk("b2b mac_reset", n_rst, 4);
    chk("b2b wren", n_wren, 20);
    chk("b2b rden", n_rden, 4);
    chk("b2b busy", n_busy, 36);

    // Single-run latency: samples 3 then 5 -> (2*5 + 4*3)/2 = 11
    clr_mon();
    send(16'd3, 0);
    t_trig = cyc;
    send(16'd5, 0);
    idle(14);
    chk("lat mac_reset", t_rst - t_trig, 1);
    chk("lat mac_reset n", n_rst, 1);
    chk("lat wren first", t_wren - t_trig, 3);
    chk("lat wren n", n_wren, 5);
    chk("lat wren span", t_wren_last - t_wren, 4);
    chk("lat flush m1", last_m1, 0);
    chk("lat flush m2", last_m2, 0);
    chk("lat rden", t_rden - t_trig, 8);
    chk("lat rden n", n_rden, 1);
    chk("lat busy first", t_busy - t_trig, 1);
    chk("lat busy n", n_busy, 9);
    chk("lat strobe", t_out - t_trig, 10);
    chk("lat y", outs[0], 32'd11);
    chk("hold out_data", out_data, 32'd11);

    // Overrun: strobes every cycle, values 1..12
    clr_mon();
    t_trig = cyc + 1;
    for (int i = 1; i <= 12; i++) send(WIDTH'(i), 0);
    idle(16);
    chk("ovr pulses", n_ovr, 4);
    chk("ovr first", t_ovr - t_trig, 3);
    chk("ovr runs", n_rst, 2);
    chk("ovr count", outs.size(), 2);
    chk("ovr y0", outs[0], 32'd31);
    chk("ovr y1", outs[1], 32'd100);

    // Full scale: two taps of -32768 x -32768
    set_coefs(16'h8000, 16'h8000, 16'h0000, 16'h0000);
    clr_mon();
    send(16'h8000, 4);
    send(16'h8000, 4);
    idle(12);
    chk("full count", outs.size(), 1);
    chk("full y", outs[0], 32'h4000_0000);

    // Reset mid-RUN
    set_coefs(16'd2, 16'd4, 16'd6, 16'd8);
    clr_mon();
    send(16'd7, 0);
    t_trig = cyc;
    send(16'd9, 0);
    idle(3);
    chk("abort pre wren", mac.mac_wren, 1);
    idle(1);
    reset = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort wren", mac.mac_wren, 0);
    chk("abort strobe", out_strobe, 0);
    chk("abort coef_addr", coef_addr, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(15);
    chk("abort no output", outs.size(), 0);
    impulse_run("post-reset");

    chk("protocol", n_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
